uart_rx_sniffer: RTL and testbench



---
 rtl/uart_rx_sniffer_pkg.sv | 21 ++
 rtl/uart_rx_fifo.sv | 63 ++++++
 rtl/uart_rx_sniffer.sv | 156 +++++++++++++++
 tb/tb_uart_rx_sniffer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_sniffer_pkg.sv
// Shared types and constants for the UART receive sniffer.
// Holds the receiver FSM encoding, the oversampling constants and the sticky-flag update helper.
package uart_rx_sniffer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } rx_state_e;

  localparam int unsigned OVERSAMPLE = 16;
  localparam logic [3:0]  MID_PHASE  = 4'(OVERSAMPLE / 2 - 1);

  // Sticky flag update: a new error event takes priority over a clear.
  function automatic logic sticky_next(input logic flag, input logic set, input logic clr);
    return set | (flag & ~clr);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through byte FIFO.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int AW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [7:0]  din,
  output logic        full,
  input  logic        pop,
  output logic [7:0]  dout,
  output logic        empty,
  output logic [AW:0] level
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_L = {1'b1, {AW{1'b0}}};

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          do_push_s;
  logic          do_pop_s;

  // Accept/qualify push and pop against the current occupancy.
  always_comb begin
    do_pop_s  = pop & (count_r != '0);
    do_push_s = push & ((count_r != DEPTH_L) | do_pop_s);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign full  = (count_r == DEPTH_L);
  assign empty = (count_r == '0);
  assign level = count_r;
  assign dout  = mem_r[rd_ptr_r];

endmodule

// File: rtl/uart_rx_sniffer.sv
// 8N1 receive decoder with 16x oversampling feeding a FWFT byte FIFO.
// Reports sticky framing-error and overflow flags.
module uart_rx_sniffer
  import uart_rx_sniffer_pkg::*;
#(
  parameter int FIFO_AW = 4,
  parameter int DIV_W   = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             rx_i,
  input  logic [DIV_W-1:0] divisor_i,
  output logic [7:0]       data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [FIFO_AW:0] level_o,
  output logic             frame_err_o,
  output logic             overflow_o,
  input  logic             clr_err_i
);

  logic             rx_meta_r;
  logic             rx_s_r;
  logic [DIV_W-1:0] div_eff_s;
  logic [DIV_W-1:0] tick_cnt_r;
  logic             tick_r;
  rx_state_e        state_r;
  logic [3:0]       ph_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shift_r;
  logic             frame_err_r;
  logic             overflow_r;
  logic             mid_s;
  logic             push_s;
  logic             frame_set_s;
  logic             pop_s;
  logic             ovf_set_s;
  logic             full_s;
  logic             empty_s;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rx_meta_r <= 1'b1;
      rx_s_r    <= 1'b1;
    end else begin
      rx_meta_r <= rx_i;
      rx_s_r    <= rx_meta_r;
    end
  end

  // Effective divisor: zero behaves as one.
  always_comb begin
    div_eff_s = divisor_i;
    if (divisor_i == '0) begin
      div_eff_s = DIV_W'(1);
    end else begin
      div_eff_s = divisor_i;
    end
  end

  // Free-running oversample tick generator.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      tick_cnt_r <= '0;
      tick_r     <= 1'b0;
    end else if (tick_cnt_r >= div_eff_s - DIV_W'(1)) begin
      tick_cnt_r <= '0;
      tick_r     <= 1'b1;
    end else begin
      tick_cnt_r <= tick_cnt_r + DIV_W'(1);
      tick_r     <= 1'b0;
    end
  end

  // Stop-bit outcome and FIFO handshake qualifiers.
  always_comb begin
    mid_s       = tick_r & (ph_r == MID_PHASE);
    push_s      = mid_s & (state_r == ST_STOP) & rx_s_r;
    frame_set_s = mid_s & (state_r == ST_STOP) & ~rx_s_r;
    pop_s       = ready_i & ~empty_s;
    ovf_set_s   = push_s & full_s & ~pop_s;
  end

  // Receiver FSM, bit-phase counter, shift register and sticky flags.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r     <= ST_IDLE;
      ph_r        <= 4'd0;
      bit_idx_r   <= 3'd0;
      shift_r     <= 8'h00;
      frame_err_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      frame_err_r <= sticky_next(frame_err_r, frame_set_s, clr_err_i);
      overflow_r  <= sticky_next(overflow_r, ovf_set_s, clr_err_i);
      if (tick_r) begin
        ph_r <= ph_r + 4'd1;
        case (state_r)
          ST_IDLE: begin
            if (!rx_s_r) begin
              ph_r    <= 4'd0;
              state_r <= ST_START;
            end
          end
          // Phase keeps running here so the next mid-point lands one full bit later.
          ST_START: begin
            if (ph_r == MID_PHASE) begin
              bit_idx_r <= 3'd0;
              state_r   <= rx_s_r ? ST_IDLE : ST_DATA;
            end
          end
          ST_DATA: begin
            if (ph_r == MID_PHASE) begin
              shift_r   <= {rx_s_r, shift_r[7:1]};
              bit_idx_r <= bit_idx_r + 3'd1;
              if (bit_idx_r == 3'd7) begin
                state_r <= ST_STOP;
              end
            end
          end
          ST_STOP: begin
            if (ph_r == MID_PHASE) begin
              state_r <= rx_s_r ? ST_IDLE : ST_WAIT_IDLE;
            end
          end
          ST_WAIT_IDLE: begin
            if (rx_s_r) begin
              state_r <= ST_IDLE;
            end
          end
          default: state_r <= ST_IDLE;
        endcase
      end
    end
  end

  uart_rx_fifo #(
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (push_s),
    .din   (shift_r),
    .full  (full_s),
    .pop   (pop_s),
    .dout  (data_o),
    .empty (empty_s),
    .level (level_o)
  );

  assign valid_o     = ~empty_s;
  assign frame_err_o = frame_err_r;
  assign overflow_o  = overflow_r;

endmodule

// File: tb/tb_uart_rx_sniffer.sv
// Scoreboard bench for uart_rx_sniffer: serial stimulus pushes expected bytes,
// a monitor pops and compares them whenever the drain port hands a byte over.
module tb_uart_rx_sniffer;

  localparam int BIT_CLKS = 64;

  logic        clk;
  logic        rst;
  logic        rx;
  logic [15:0] div;
  logic [7:0]  data;
  logic        valid;
  logic        ready;
  logic [4:0]  level;
  logic        frame_err;
  logic        overflow;
  logic        clr_err;

  int          checks;
  int          errors;
  logic [7:0]  exp_q [$];
  logic        found;

  uart_rx_sniffer #(
    .FIFO_AW (4),
    .DIV_W   (16)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .rx_i        (rx),
    .divisor_i   (div),
    .data_o      (data),
    .valid_o     (valid),
    .ready_i     (ready),
    .level_o     (level),
    .frame_err_o (frame_err),
    .overflow_o  (overflow),
    .clr_err_i   (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic v, input int n);
    rx = v;
    cyc(n);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic expect_push);
    if (expect_push) exp_q.push_back(b);
    send_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) send_bit(b[i], BIT_CLKS);
    send_bit(1'b1, BIT_CLKS);
  endtask

  task automatic drain();
    ready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) cyc(1);
    ready = 1'b0;
    cyc(1);
    check("drain_done", 32'(exp_q.size()), 32'd0);
    check("drain_valid", 32'(valid), 32'd0);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    cyc(1);
    clr_err = 1'b0;
    cyc(1);
  endtask

  // Monitor: every accepted handshake must match the oldest expected byte.
  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte: got 0x%0h, expected no byte", data);
      end else begin
        check("drain_data", 32'(data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    rx      = 1'b1;
    ready   = 1'b0;
    clr_err = 1'b0;
    div     = 16'd4;
    cyc(5);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    cyc(100);

    // Single byte
    send_byte(8'h55, 1'b1);
    check("single_level", 32'(level), 32'd1);
    check("single_valid", 32'(valid), 32'd1);
    drain();
    check("single_level0", 32'(level), 32'd0);

    // Back-to-back without idle gap
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'hA3, 1'b1);
    check("b2b_level", 32'(level), 32'd3);
    check("b2b_ferr", 32'(frame_err), 32'd0);
    check("b2b_ovf", 32'(overflow), 32'd0);
    drain();

    // Glitch on idle line
    send_bit(1'b0, 20);
    send_bit(1'b1, 200);
    check("glitch_level", 32'(level), 32'd0);
    check("glitch_ferr", 32'(frame_err), 32'd0);

    // Framing error: stop bit low for two bit times
    send_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) send_bit(((8'h3C >> i) & 8'h01) != 8'h00, BIT_CLKS);
    send_bit(1'b0, 2 * BIT_CLKS);
    send_bit(1'b1, BIT_CLKS);
    check("ferr_set", 32'(frame_err), 32'd1);
    check("ferr_level", 32'(level), 32'd0);
    send_byte(8'h81, 1'b1);
    check("ferr_next_level", 32'(level), 32'd1);
    check("ferr_still", 32'(frame_err), 32'd1);
    drain();
    pulse_clr();
    check("ferr_clr", 32'(frame_err), 32'd0);

    // Overflow: 17 bytes into 16 entries
    for (int k = 1; k <= 17; k++) send_byte(8'(k), k <= 16);
    check("ovf_level", 32'(level), 32'd16);
    check("ovf_flag", 32'(overflow), 32'd1);
    pulse_clr();
    check("ovf_clr", 32'(overflow), 32'd0);

    // Full FIFO: pop exactly on the push cycle of 0x77
    found = 1'b0;
    fork
      send_byte(8'h77, 1'b1);
      begin
        for (int i = 0; i < 800 && !found; i++) begin
          cyc(1);
          if (dut.push_s) begin
            ready = 1'b1;
            cyc(1);
            ready = 1'b0;
            found = 1'b1;
          end
        end
      end
    join
    check("fullpop_seen", 32'(found), 32'd1);
    check("fullpop_level", 32'(level), 32'd16);
    check("fullpop_ovf", 32'(overflow), 32'd0);
    drain();

    // Reset during bit 4 of 0xC5, released during bit 6 (line high)
    send_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) send_bit(((8'hC5 >> i) & 8'h01) != 8'h00, BIT_CLKS);
    send_bit(1'b0, BIT_CLKS / 2);
    rst = 1'b1;
    send_bit(1'b0, BIT_CLKS / 2);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_level", 32'(level), 32'd0);
    check("midrst_data", 32'(data), 32'd0);
    check("midrst_ferr", 32'(frame_err), 32'd0);
    check("midrst_ovf", 32'(overflow), 32'd0);
    send_bit(1'b0, BIT_CLKS);
    send_bit(1'b1, BIT_CLKS / 2);
    rst = 1'b0;
    send_bit(1'b1, BIT_CLKS / 2);
    send_bit(1'b1, BIT_CLKS);
    send_bit(1'b1, 2 * BIT_CLKS);
    check("midrst_nobyte", 32'(level), 32'd0);
    send_byte(8'h5A, 1'b1);
    check("post_rst_level", 32'(level), 32'd1);
    drain();

    check("final_queue", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
